// File: rtl/lcd_reader.sv
// HD44780-class read-cycle controller: one RW=1 bus cycle per start edge, or a
// busy-flag poll that repeats reads until BF clears or the read budget runs out.
module lcd_reader #(
  parameter int SETUP_CYC = 2,
  parameter int EN_CYC    = 16,
  parameter int HOLD_CYC  = 2,
  parameter int GAP_CYC   = 16,
  parameter int POLL_MAX  = 255
) (
  input  logic       iCLK,
  input  logic       iRST,
  input  logic       iStart,
  input  logic       iRS,
  input  logic       iPoll,
  input  logic [7:0] LCD_DATA,
  output logic [7:0] oDATA,
  output logic       oDone,
  output logic       oBusy,
  output logic       oTimeout,
  output logic       LCD_RW,
  output logic       LCD_EN,
  output logic       LCD_RS
);

  // state | meaning
  // IDLE  | waiting for a start edge, RW=0
  // SETUP | RS/RW stable, EN low
  // EN_HI | EN high, data sampled on exit
  // HOLD  | RS/RW held after EN falls, then decide
  // GAP   | EN-low spacing between poll reads
  typedef enum logic [2:0] {IDLE, SETUP, EN_HI, HOLD, GAP} state_t;

  localparam logic [7:0] SETUP_LD = 8'(SETUP_CYC - 1);
  localparam logic [7:0] EN_LD    = 8'(EN_CYC - 1);
  localparam logic [7:0] HOLD_LD  = 8'(HOLD_CYC - 1);
  localparam logic [7:0] GAP_LD   = 8'(GAP_CYC - 1);
  localparam logic [7:0] POLL_LIM = 8'(POLL_MAX);

  state_t     state, state_nxt;
  logic [7:0] cnt, cnt_nxt;
  logic [7:0] rd_cnt, rd_cnt_nxt;
  logic [7:0] data_nxt;
  logic       poll_mode, poll_nxt;
  logic       pre_start;
  logic       done_nxt, busy_nxt, to_nxt, rw_nxt, en_nxt, rs_nxt;
  logic       start_edge, cnt_zero, bf_retry;

  assign start_edge = iStart & ~pre_start;
  assign cnt_zero   = (cnt == 8'd0);
  // oDATA and rd_cnt already reflect the read that just completed
  assign bf_retry   = poll_mode & oDATA[7] & (rd_cnt < POLL_LIM);

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state     <= IDLE;
      cnt       <= '0;
      rd_cnt    <= '0;
      poll_mode <= 1'b0;
      pre_start <= 1'b0;
      oDATA     <= '0;
      oDone     <= 1'b0;
      oBusy     <= 1'b0;
      oTimeout  <= 1'b0;
      LCD_RW    <= 1'b0;
      LCD_EN    <= 1'b0;
      LCD_RS    <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      rd_cnt    <= rd_cnt_nxt;
      poll_mode <= poll_nxt;
      pre_start <= iStart;
      oDATA     <= data_nxt;
      oDone     <= done_nxt;
      oBusy     <= busy_nxt;
      oTimeout  <= to_nxt;
      LCD_RW    <= rw_nxt;
      LCD_EN    <= en_nxt;
      LCD_RS    <= rs_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_edge) state_nxt = SETUP;
      SETUP:   if (cnt_zero)   state_nxt = EN_HI;
      EN_HI:   if (cnt_zero)   state_nxt = HOLD;
      HOLD:    if (cnt_zero)   state_nxt = bf_retry ? GAP : IDLE;
      GAP:     if (cnt_zero)   state_nxt = SETUP;
      default:                 state_nxt = IDLE;
    endcase
  end

  always_comb begin
    cnt_nxt    = cnt;
    rd_cnt_nxt = rd_cnt;
    poll_nxt   = poll_mode;
    data_nxt   = oDATA;
    done_nxt   = oDone;
    busy_nxt   = oBusy;
    to_nxt     = oTimeout;
    rw_nxt     = LCD_RW;
    rs_nxt     = LCD_RS;
    en_nxt     = (state_nxt == EN_HI);

    if (state != IDLE) cnt_nxt = cnt - 8'd1;
    if (state_nxt != state) begin
      case (state_nxt)
        SETUP:   cnt_nxt = SETUP_LD;
        EN_HI:   cnt_nxt = EN_LD;
        HOLD:    cnt_nxt = HOLD_LD;
        GAP:     cnt_nxt = GAP_LD;
        default: cnt_nxt = '0;
      endcase
    end

    if (state == IDLE && state_nxt == SETUP) begin
      poll_nxt   = iPoll;
      rs_nxt     = iPoll ? 1'b0 : iRS;
      rw_nxt     = 1'b1;
      busy_nxt   = 1'b1;
      done_nxt   = 1'b0;
      to_nxt     = 1'b0;
      rd_cnt_nxt = '0;
    end

    if (state == EN_HI && state_nxt == HOLD) begin
      data_nxt   = LCD_DATA;
      rd_cnt_nxt = rd_cnt + 8'd1;
    end

    if (state == HOLD && state_nxt == IDLE) begin
      rw_nxt   = 1'b0;
      busy_nxt = 1'b0;
      done_nxt = 1'b1;
      to_nxt   = poll_mode & oDATA[7];
    end
  end

endmodule

// File: tb/tb_lcd_reader.sv
// Directed bench for lcd_reader: table of read transactions plus hand-written
// sequences for start-while-busy and asynchronous reset mid-cycle.
module tb_lcd_reader;

  logic       iCLK = 1'b0;
  logic       iRST = 1'b1;
  logic       iStart = 1'b0;
  logic       iRS = 1'b0;
  logic       iPoll = 1'b0;
  logic [7:0] LCD_DATA = 8'h00;
  logic [7:0] oDATA;
  logic       oDone, oBusy, oTimeout, LCD_RW, LCD_EN, LCD_RS;

  int n_cmp = 0;
  int n_fail = 0;

  lcd_reader #(.SETUP_CYC(2), .EN_CYC(16), .HOLD_CYC(2), .GAP_CYC(16), .POLL_MAX(4)) dut (
    .iCLK(iCLK), .iRST(iRST), .iStart(iStart), .iRS(iRS), .iPoll(iPoll),
    .LCD_DATA(LCD_DATA), .oDATA(oDATA), .oDone(oDone), .oBusy(oBusy),
    .oTimeout(oTimeout), .LCD_RW(LCD_RW), .LCD_EN(LCD_EN), .LCD_RS(LCD_RS)
  );

  always #10 iCLK = ~iCLK;

  typedef struct {
    logic       rs;
    logic       poll;
    logic [7:0] busy_data;
    int         busy_reads;
    logic [7:0] final_data;
    logic [7:0] after_data;
    int         exp_pulses;
    int         exp_done;
    logic [7:0] exp_data;
    logic       exp_rs;
    logic       exp_to;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] data_for(input vec_t v, input int n);
    if (n < v.busy_reads) return v.busy_data;
    if (n == v.busy_reads) return v.final_data;
    return v.after_data;
  endfunction

  task automatic run_vec(input vec_t v, input int idx);
    int k, done_k, pulses, falls, first_rise, prev_rise, cur_w;
    logic w_ok, sp_ok, ctl_ok, en_prev;
    string p;
    p = $sformatf("v%0d", idx);
    iRS = v.rs; iPoll = v.poll;
    LCD_DATA = data_for(v, 0);
    done_k = -1; pulses = 0; falls = 0; first_rise = -1; prev_rise = -1; cur_w = 0;
    w_ok = 1'b1; sp_ok = 1'b1; ctl_ok = 1'b1; en_prev = 1'b0;
    @(negedge iCLK); iStart = 1'b1;
    @(posedge iCLK);
    for (k = 0; k < 400; k++) begin
      @(negedge iCLK);
      if (k == 0) iStart = 1'b0;
      if (LCD_EN && !en_prev) begin
        pulses++;
        if (first_rise < 0) first_rise = k;
        else if (k - prev_rise != 36) sp_ok = 1'b0;
        prev_rise = k;
        cur_w = 0;
      end
      if (LCD_EN) cur_w++;
      if (!LCD_EN && en_prev) begin
        falls++;
        if (cur_w != 16) w_ok = 1'b0;
        LCD_DATA = data_for(v, falls);
      end
      en_prev = LCD_EN;
      if (oDone) begin
        done_k = k;
        break;
      end
      if (!LCD_RW || !oBusy || LCD_RS !== v.exp_rs) ctl_ok = 1'b0;
      @(posedge iCLK);
    end
    chk({p, "_done_cycle"}, done_k, v.exp_done);
    chk({p, "_pulses"}, pulses, v.exp_pulses);
    chk({p, "_first_rise"}, first_rise, 2);
    chk({p, "_en_width"}, w_ok, 1'b1);
    chk({p, "_spacing"}, sp_ok, 1'b1);
    chk({p, "_ctl_during"}, ctl_ok, 1'b1);
    chk({p, "_ctl_done"}, {oBusy, LCD_RW, LCD_EN}, 3'b000);
    chk({p, "_data"}, oDATA, v.exp_data);
    chk({p, "_timeout"}, oTimeout, v.exp_to);
    chk({p, "_rs"}, LCD_RS, v.exp_rs);
    repeat (3) @(negedge iCLK);
  endtask

  initial begin
    int k, done_k, pulses;
    logic en_prev;

    //          rs    poll  busy   nb  final  after  pls done data   rs    to
    vecs[0] = '{1'b0, 1'b0, 8'h00, 0,  8'h25, 8'hC3, 1,  20,  8'h25, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 1'b0, 8'h00, 0,  8'h41, 8'hFF, 1,  20,  8'h41, 1'b1, 1'b0};
    vecs[2] = '{1'b0, 1'b0, 8'h00, 0,  8'h80, 8'h11, 1,  20,  8'h80, 1'b0, 1'b0};
    vecs[3] = '{1'b1, 1'b1, 8'h80, 3,  8'h07, 8'h07, 4,  128, 8'h07, 1'b0, 1'b0};
    vecs[4] = '{1'b0, 1'b1, 8'h8A, 99, 8'h8A, 8'h8A, 4,  128, 8'h8A, 1'b0, 1'b1};
    vecs[5] = '{1'b1, 1'b1, 8'h00, 0,  8'h3C, 8'hF0, 1,  20,  8'h3C, 1'b0, 1'b0};
    vecs[6] = '{1'b0, 1'b1, 8'hFF, 1,  8'h7F, 8'h9E, 2,  56,  8'h7F, 1'b0, 1'b0};
    vecs[7] = '{1'b1, 1'b0, 8'h00, 0,  8'h00, 8'hAA, 1,  20,  8'h00, 1'b1, 1'b0};

    #3;
    chk("rst_ctl", {LCD_EN, LCD_RW, LCD_RS, oBusy, oDone, oTimeout}, 6'b0);
    chk("rst_data", oDATA, 8'h00);
    repeat (2) @(negedge iCLK);
    iRST = 1'b0;
    repeat (2) @(negedge iCLK);

    for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

    // second start edge at E10 must be dropped; later edge restarts
    iRS = 1'b0; iPoll = 1'b0; LCD_DATA = 8'h55;
    done_k = -1; pulses = 0; en_prev = 1'b0;
    @(negedge iCLK); iStart = 1'b1;
    @(posedge iCLK);
    for (k = 0; k < 60; k++) begin
      @(negedge iCLK);
      if (k == 0) iStart = 1'b0;
      if (k == 9) iStart = 1'b1;
      if (LCD_EN && !en_prev) pulses++;
      en_prev = LCD_EN;
      if (oDone) begin
        done_k = k;
        break;
      end
      @(posedge iCLK);
    end
    chk("busy_pulses", pulses, 1);
    chk("busy_done_cycle", done_k, 20);
    chk("busy_data", oDATA, 8'h55);
    repeat (3) @(negedge iCLK);
    chk("busy_no_queue", {oDone, oBusy, LCD_RW}, 3'b100);
    iStart = 1'b0;
    LCD_DATA = 8'h66;
    @(negedge iCLK); iStart = 1'b1;
    @(posedge iCLK); #1;
    chk("restart_accept", {oDone, oBusy, LCD_RW}, 3'b011);
    done_k = -1;
    for (k = 0; k < 40; k++) begin
      @(negedge iCLK);
      if (oDone) begin
        done_k = k;
        break;
      end
    end
    iStart = 1'b0;
    chk("restart_done_cycle", done_k, 20);
    chk("restart_data", oDATA, 8'h66);
    repeat (3) @(negedge iCLK);

    // async reset while EN is high
    iRS = 1'b1; iPoll = 1'b0; LCD_DATA = 8'h12;
    @(negedge iCLK); iStart = 1'b1;
    @(negedge iCLK); iStart = 1'b0;
    for (int i = 0; i < 10 && !LCD_EN; i++) @(negedge iCLK);
    chk("rstmid_en_seen", LCD_EN, 1'b1);
    #3 iRST = 1'b1;
    #2;
    chk("rstmid_ctl", {LCD_EN, LCD_RW, LCD_RS, oBusy, oDone, oTimeout}, 6'b0);
    chk("rstmid_data", oDATA, 8'h00);
    repeat (2) @(negedge iCLK);
    iRST = 1'b0;
    repeat (3) @(negedge iCLK);
    chk("rstmid_idle", {LCD_EN, LCD_RW, oBusy, oDone}, 4'b0);
    run_vec(vecs[1], 8);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no end of test, expected end of test");
    $fatal(1);
  end

endmodule
